// File: rtl/itransform_block.sv
// 4x4 inverse integer transform with prediction add and 8-bit clipping.
// A vertical pass and then a horizontal pass each take one cycle per column or row. Blocks flagged all-zero bypass the transform and copy the prediction.
module itransform_block #(
  parameter int BLOCK_SIZE = 4,
  parameter int IW         = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [IW*BLOCK_SIZE*BLOCK_SIZE-1:0]  in,
  input  logic                                 nz,
  input  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]   pred,
  output logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]   dst,
  output logic                                 busy,
  output logic                                 done
);

  localparam int NPIX = BLOCK_SIZE * BLOCK_SIZE;
  localparam logic signed [17:0] KC1 = 18'sd85627;
  localparam logic signed [17:0] KC2 = 18'sd35468;

  typedef enum logic [2:0] {IDLE, VPASS, HPASS, BYPASS, DONE} state_t;

  state_t                state, state_nxt;
  logic [1:0]            k;
  logic signed [IW-1:0]  in_q   [NPIX];
  logic [7:0]            pred_q [NPIX];
  logic signed [31:0]    tmp    [NPIX];
  logic [7:0]            dst_q  [NPIX];

  logic signed [31:0]    s [4];
  logic signed [31:0]    v [4];
  logic signed [31:0]    dc, a, b, c, d;
  logic [7:0]            rec [4];
  logic                  accept;

  function automatic logic signed [31:0] mul(input logic signed [31:0] x,
                                             input logic signed [17:0] cf);
    return 32'(($signed({{32{x[31]}}, x}) * $signed({{46{cf[17]}}, cf})) >>> 16);
  endfunction

  function automatic logic [7:0] clip8(input logic [7:0] p, input logic signed [31:0] x);
    logic signed [31:0] sh;
    logic signed [32:0] sum;
    sh  = x >>> 3;
    sum = $signed({25'd0, p}) + $signed({sh[31], sh});
    if (sum < 0)
      return 8'd0;
    else if (sum > 33'sd255)
      return 8'd255;
    else
      return sum[7:0];
  endfunction

  assign accept = start && (state == IDLE || state == DONE);

  // Shared butterfly: VPASS walks columns of the coefficients, HPASS walks rows of tmp.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      if (state == VPASS)
        s[r] = {{(32-IW){in_q[{2'(r), k}][IW-1]}}, in_q[{2'(r), k}]};
      else
        s[r] = tmp[{2'(r), k}];
    end
    dc   = s[0] + ((state == HPASS) ? 32'sd4 : 32'sd0);
    a    = dc + s[2];
    b    = dc - s[2];
    c    = mul(s[1], KC2) - mul(s[3], KC1);
    d    = mul(s[1], KC1) + mul(s[3], KC2);
    v[0] = a + d;
    v[1] = b + c;
    v[2] = b - c;
    v[3] = a - d;
    for (int j = 0; j < 4; j++)
      rec[j] = clip8(pred_q[{k, 2'(j)}], v[j]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= 2'd0;
      for (int i = 0; i < NPIX; i++) begin
        in_q[i]   <= '0;
        pred_q[i] <= '0;
        tmp[i]    <= '0;
        dst_q[i]  <= '0;
      end
    end else begin
      state <= state_nxt;
      if (accept) begin
        k <= 2'd0;
        for (int i = 0; i < NPIX; i++) begin
          in_q[i]   <= $signed(in[IW*i +: IW]);
          pred_q[i] <= pred[8*i +: 8];
        end
      end else if (state == VPASS || state == HPASS) begin
        k <= k + 2'd1;
      end
      if (state == VPASS)
        for (int j = 0; j < 4; j++)
          tmp[{k, 2'(j)}] <= v[j];
      if (state == HPASS)
        for (int j = 0; j < 4; j++)
          dst_q[{k, 2'(j)}] <= rec[j];
      if (state == BYPASS)
        for (int i = 0; i < NPIX; i++)
          dst_q[i] <= pred_q[i];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start)
          state_nxt = nz ? VPASS : BYPASS;
        else
          state_nxt = IDLE;
      end
      VPASS:   state_nxt = (k == 2'd3) ? HPASS : VPASS;
      HPASS:   state_nxt = (k == 2'd3) ? DONE : HPASS;
      BYPASS:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
    dst  = '0;
    for (int i = 0; i < NPIX; i++)
      dst[8*i +: 8] = dst_q[i];
  end

endmodule
